obj_dma_scheduler: RTL and testbench

OBJ_DMA_SCHEDULER -- requirements
Module: obj_dma_scheduler

---
 rtl/obj_dma_scheduler.sv | 167 ++++++++++++++++
 tb/tb_obj_dma_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_dma_scheduler.sv
// Object-RAM to object-buffer DMA scheduler: one 1024-byte copy per frame,
// started at V479/H128, sharing the object-RAM port with the CPU.
module obj_dma_scheduler (
   input  logic       i_EMU_MCLK,
   input  logic       i_MRST_n,
   input  logic       i_EMU_CLK6MPCEN_n,
   input  logic [8:0] i_HCNTR,
   input  logic [8:0] i_VCNTR,
   input  logic       i_DMA_EN,
   input  logic       i_CPU_REQ,
   input  logic [9:0] i_CPU_ADDR,
   output logic       o_CPU_WAIT_n,
   output logic       o_CPU_ACK,
   output logic [9:0] o_SRC_ADDR,
   output logic       o_SRC_RD,
   input  logic [7:0] i_SRC_DATA,
   output logic [9:0] o_DST_ADDR,
   output logic [7:0] o_DST_DATA,
   output logic       o_DST_WE,
   output logic       o_DMA_BUSY,
   output logic       o_DMA_DONE,
   output logic       o_DMA_ERR
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [8:0] START_V = 9'd479;
   localparam logic [8:0] START_H = 9'd128;
   localparam logic [8:0] ABORT_V = 9'd495;
   localparam logic [9:0] LAST_C  = 10'd1023;

   state_t     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic       src_rd_q, src_rd_d;
   logic       dst_we_q, dst_we_d;
   logic [9:0] dst_addr_q, dst_addr_d;
   logic [7:0] dst_data_q, dst_data_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       ack_q, ack_d;

   logic en_s;
   logic start_s;
   logic abort_s;

   assign en_s    = ~i_EMU_CLK6MPCEN_n;
   assign start_s = (i_VCNTR == START_V) && (i_HCNTR == START_H) && i_DMA_EN;
   assign abort_s = (i_VCNTR == ABORT_V);

   // Next-state logic; strobes fall back to zero on every enable cycle
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      src_rd_d   = src_rd_q;
      dst_we_d   = dst_we_q;
      dst_addr_d = dst_addr_q;
      dst_data_d = dst_data_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      ack_d      = ack_q;
      if (en_s) begin
         src_rd_d = 1'b0;
         dst_we_d = 1'b0;
         done_d   = 1'b0;
         ack_d    = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  state_d  = ST_RD;
                  cnt_d    = 10'd0;
                  err_d    = 1'b0;
                  busy_d   = 1'b1;
                  src_rd_d = 1'b1;
               end else if (i_CPU_REQ) begin
                  // Alternate grant cycles so a held request acks every 2nd enable
                  ack_d = ~ack_q;
               end else begin
                  ack_d = 1'b0;
               end
            end
            ST_RD: begin
               if (abort_s) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end else begin
                  state_d    = ST_WR;
                  dst_we_d   = 1'b1;
                  dst_addr_d = cnt_q;
                  dst_data_d = i_SRC_DATA;
               end
            end
            ST_WR: begin
               if (abort_s) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end else if (cnt_q == LAST_C) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d  = ST_RD;
                  cnt_d    = cnt_q + 10'd1;
                  src_rd_d = 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and registered outputs
   always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 10'd0;
         src_rd_q   <= 1'b0;
         dst_we_q   <= 1'b0;
         dst_addr_q <= 10'd0;
         dst_data_q <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         src_rd_q   <= src_rd_d;
         dst_we_q   <= dst_we_d;
         dst_addr_q <= dst_addr_d;
         dst_data_q <= dst_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ack_q      <= ack_d;
      end
   end

   // A write already on the bus is killed in the very cycle the window closes
   assign o_DST_WE     = dst_we_q & ~abort_s;
   assign o_SRC_ADDR   = busy_q ? cnt_q : i_CPU_ADDR;
   assign o_CPU_WAIT_n = ~(busy_q & i_CPU_REQ);
   assign o_SRC_RD     = src_rd_q;
   assign o_DST_ADDR   = dst_addr_q;
   assign o_DST_DATA   = dst_data_q;
   assign o_DMA_BUSY   = busy_q;
   assign o_DMA_DONE   = done_q;
   assign o_DMA_ERR    = err_q;
   assign o_CPU_ACK    = ack_q;

endmodule

// File: tb/tb_obj_dma_scheduler.sv
// Scoreboard bench for obj_dma_scheduler: expected writes are queued at each
// frame start and popped as the DUT strobes the object buffer.
module tb_obj_dma_scheduler;

   logic       clk;
   logic       rst_n;
   logic       cen_n;
   logic [8:0] hcntr;
   logic [8:0] vcntr;
   logic       dma_en;
   logic       cpu_req;
   logic [9:0] cpu_addr;
   logic       cpu_wait_n;
   logic       cpu_ack;
   logic [9:0] src_addr;
   logic       src_rd;
   logic [7:0] src_data;
   logic [9:0] dst_addr;
   logic [7:0] dst_data;
   logic       dst_we;
   logic       dma_busy;
   logic       dma_done;
   logic       dma_err;

   obj_dma_scheduler u_dut (
      .i_EMU_MCLK        (clk),
      .i_MRST_n          (rst_n),
      .i_EMU_CLK6MPCEN_n (cen_n),
      .i_HCNTR           (hcntr),
      .i_VCNTR           (vcntr),
      .i_DMA_EN          (dma_en),
      .i_CPU_REQ         (cpu_req),
      .i_CPU_ADDR        (cpu_addr),
      .o_CPU_WAIT_n      (cpu_wait_n),
      .o_CPU_ACK         (cpu_ack),
      .o_SRC_ADDR        (src_addr),
      .o_SRC_RD          (src_rd),
      .i_SRC_DATA        (src_data),
      .o_DST_ADDR        (dst_addr),
      .o_DST_DATA        (dst_data),
      .o_DST_WE          (dst_we),
      .o_DMA_BUSY        (dma_busy),
      .o_DMA_DONE        (dma_done),
      .o_DMA_ERR         (dma_err)
   );

   // Object RAM contents: a fixed pattern that differs from the address
   function automatic logic [7:0] src_byte(input logic [9:0] a);
      return a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h5A;
   endfunction

   assign src_data = src_byte(src_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int k      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [17:0] exp_q[$];
   logic [9:0]  rd_next  = 10'd0;
   int          we_cnt   = 0;
   int          rd_cnt   = 0;
   int          done_cnt = 0;
   int          ack_cnt  = 0;
   int          ack_busy = 0;
   int          wait_bad = 0;

   // Monitor: samples once per enable cycle, away from the active edge
   always @(negedge clk) begin
      if (rst_n && !cen_n) begin
         if (dst_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
               chk("we_unexpected", 32'd1, 32'd0);
            end else begin
               chk("we_addr_data", {14'd0, dst_addr, dst_data}, {14'd0, exp_q.pop_front()});
            end
         end
         if (src_rd) begin
            rd_cnt++;
            chk("rd_addr", {22'd0, src_addr}, {22'd0, rd_next});
            rd_next = rd_next + 10'd1;
         end
         if (dma_done) done_cnt++;
         if (cpu_ack) ack_cnt++;
         if (cpu_ack && dma_busy) ack_busy++;
         if (dma_busy && cpu_req && cpu_wait_n) wait_bad++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic run_to(input int target);
      while (k < target) step();
   endtask

   // Present the frame-start coordinates for one enable cycle
   task automatic kick(input bit expect_xfer);
      if (expect_xfer) begin
         exp_q.delete();
         for (int a = 0; a < 1024; a++) begin
            exp_q.push_back({a[9:0], src_byte(a[9:0])});
         end
         rd_next = 10'd0;
      end
      vcntr = 9'd479;
      hcntr = 9'd128;
      k = 0;
      step();
      vcntr = 9'd300;
      hcntr = 9'd200;
   endtask

   task automatic wait_done(input int limit, output int lat);
      while (!dma_done && k < limit) step();
      lat = k;
   endtask

   int lat;
   int j;
   int snap_we, snap_rd, snap_done, snap_ack;
   logic [31:0] frozen;

   initial begin
      rst_n    = 1'b0;
      cen_n    = 1'b0;
      vcntr    = 9'd300;
      hcntr    = 9'd200;
      dma_en   = 1'b0;
      cpu_req  = 1'b0;
      cpu_addr = 10'h155;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {7'd0, src_rd, dst_we, dst_addr, dst_data, dma_busy, dma_done, dma_err, cpu_ack, cpu_wait_n},
          {7'd0, 1'b0, 1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      chk("reset_src_mux", {22'd0, src_addr}, {22'd0, 10'h155});
      rst_n = 1'b1;
      step();
      step();

      // Full transfer, with a retrigger attempt and DMA_EN dropped mid-way
      dma_en  = 1'b1;
      snap_we = we_cnt;
      kick(1'b1);
      chk("start_busy", {31'd0, dma_busy}, 32'd1);
      run_to(100);
      vcntr  = 9'd479;
      hcntr  = 9'd128;
      dma_en = 1'b0;
      step();
      vcntr = 9'd300;
      hcntr = 9'd200;
      wait_done(3000, lat);
      chk("full_done_lat", lat, 32'd2049);
      chk("full_we_count", we_cnt - snap_we, 32'd1024);
      chk("full_queue_empty", exp_q.size(), 32'd0);
      step();
      chk("full_after", {29'd0, dma_busy, dma_done, dma_err}, 32'd0);
      dma_en = 1'b1;

      // CPU contention across the start
      cpu_req = 1'b1;
      repeat (3) step();
      snap_done = ack_busy;
      snap_rd   = wait_bad;
      kick(1'b1);
      chk("cont_start", {29'd0, cpu_ack, dma_busy, cpu_wait_n}, {29'd0, 3'b010});
      wait_done(3000, lat);
      chk("cont_done_lat", lat, 32'd2049);
      chk("cont_ack_in_busy", ack_busy - snap_done, 32'd0);
      chk("cont_wait_released", wait_bad - snap_rd, 32'd0);
      j = 0;
      while (!cpu_ack && j < 10) begin
         step();
         j++;
      end
      chk("cont_first_ack", j, 32'd2);
      cpu_req = 1'b0;
      step();
      step();

      // Abort in RD at counter 500
      snap_we   = we_cnt;
      snap_done = done_cnt;
      kick(1'b1);
      run_to(1001);
      chk("abort_rd_addr", {21'd0, src_rd, src_addr}, {21'd0, 1'b1, 10'd500});
      vcntr = 9'd495;
      step();
      chk("abort_outs", {28'd0, dma_busy, dma_err, dma_done, dst_we}, {28'd0, 4'b0100});
      repeat (5) step();
      vcntr = 9'd300;
      chk("abort_we_count", we_cnt - snap_we, 32'd500);
      chk("abort_queue_left", exp_q.size(), 32'd524);
      chk("abort_no_done", done_cnt - snap_done, 32'd0);
      chk("abort_err_sticky", {31'd0, dma_err}, 32'd1);

      // Next start clears ERR; abort landing in WR kills the strobe at once
      snap_we = we_cnt;
      kick(1'b1);
      chk("restart_err_clr", {30'd0, dma_busy, dma_err}, {30'd0, 2'b10});
      run_to(22);
      vcntr = 9'd495;
      #1;
      chk("abort_wr_we_gated", {31'd0, dst_we}, 32'd0);
      step();
      vcntr = 9'd300;
      chk("abort_wr_outs", {30'd0, dma_busy, dma_err}, {30'd0, 2'b01});
      chk("abort_wr_we_count", we_cnt - snap_we, 32'd10);
      chk("abort_wr_queue_left", exp_q.size(), 32'd1014);
      exp_q.delete();

      // Disabled frame: no strobes, CPU keeps getting acks
      dma_en   = 1'b0;
      cpu_req  = 1'b1;
      snap_we  = we_cnt;
      snap_rd  = rd_cnt;
      snap_ack = ack_cnt;
      kick(1'b0);
      repeat (9) step();
      chk("dis_rd_count", rd_cnt - snap_rd, 32'd0);
      chk("dis_we_count", we_cnt - snap_we, 32'd0);
      chk("dis_ack_count", ack_cnt - snap_ack, 32'd5);
      chk("dis_busy", {31'd0, dma_busy}, 32'd0);
      cpu_req = 1'b0;
      dma_en  = 1'b1;
      step();

      // Reset mid-transfer at counter 300
      snap_done = done_cnt;
      kick(1'b1);
      run_to(601);
      chk("rst_rd_addr", {21'd0, src_rd, src_addr}, {21'd0, 1'b1, 10'd300});
      rst_n = 1'b0;
      #1;
      chk("rst_async_outs", {7'd0, src_rd, dst_we, dst_addr, dst_data, dma_busy, dma_done, dma_err, cpu_ack, cpu_wait_n},
          {7'd0, 1'b0, 1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      exp_q.delete();
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("rst_no_done_err", {31'd0, dma_err}, 32'd0);
      chk("rst_no_done", done_cnt - snap_done, 32'd0);
      snap_we = we_cnt;
      kick(1'b1);
      wait_done(3000, lat);
      chk("rst_next_lat", lat, 32'd2049);
      chk("rst_next_we", we_cnt - snap_we, 32'd1024);
      chk("rst_next_queue", exp_q.size(), 32'd0);
      step();
      step();

      // Enable held off for 10 MCLKs mid-transfer
      snap_we = we_cnt;
      kick(1'b1);
      run_to(201);
      cen_n  = 1'b1;
      frozen = {9'd0, src_rd, src_addr, dst_we, dst_addr, dma_busy};
      repeat (10) @(posedge clk);
      #1;
      chk("gate_frozen", {9'd0, src_rd, src_addr, dst_we, dst_addr, dma_busy}, frozen);
      chk("gate_frozen_rd", {21'd0, src_rd, src_addr}, {21'd0, 1'b1, 10'd100});
      cen_n = 1'b0;
      wait_done(3000, lat);
      chk("gate_done_lat", lat, 32'd2049);
      chk("gate_we_count", we_cnt - snap_we, 32'd1024);
      chk("gate_queue_empty", exp_q.size(), 32'd0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
